// File: rtl/pll_cfg_pkg.sv
// Shared constants for the PLL configuration assembler: frame command
// codes, segment/word geometry and the assembly FSM encoding.
package pll_cfg_pkg;

    // Frame command codes (frame_data[15:12]); writes match on the top two bits
    localparam logic [3:0] CMD_NOP = 4'h0;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [3:0] CMD_RD  = 4'h8;
    localparam logic [3:0] CMD_RUN = 4'hC;

    // Geometry of the configuration words
    localparam int SEG_W     = 12;
    localparam int WORD_W    = 48;
    localparam int NUM_WORDS = 4;

    // Assembly FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ASM    = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/pll_cfg_readback.sv
// Register readback path: auto-incrementing {word, segment} read pointer and
// the segment mux that forms the 16-bit readback frame for the SPI shifter.
module pll_cfg_readback
    import pll_cfg_pkg::*;
#(
    parameter int NUM_SEG = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rd_stb,
    input  logic                               ptr_clr,
    input  logic [NUM_WORDS*SEG_W*NUM_SEG-1:0] cfg_word,
    output logic                               tx_valid,
    output logic [15:0]                        tx_data
);

    localparam int SCW = $clog2(NUM_SEG);

    logic [1:0]       rp_reg;
    logic [SCW-1:0]   rp_seg;
    logic [SEG_W-1:0] seg_tbl [NUM_WORDS][NUM_SEG];

    // Segment 0 is the most significant slice of each word
    for (genvar r = 0; r < NUM_WORDS; r++) begin : g_reg
        for (genvar s = 0; s < NUM_SEG; s++) begin : g_seg
            assign seg_tbl[r][s] = cfg_word[(r*NUM_SEG + (NUM_SEG-1-s))*SEG_W +: SEG_W];
        end
    end

    // Read pointer: segment order within a word, then next word, wrapping to 0/0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rp_reg <= '0;
            rp_seg <= '0;
        end else if (ptr_clr) begin
            rp_reg <= '0;
            rp_seg <= '0;
        end else if (rd_stb) begin
            if (rp_seg == SCW'(NUM_SEG-1)) begin
                rp_seg <= '0;
                rp_reg <= rp_reg + 2'd1;
            end else begin
                rp_seg <= rp_seg + 1'b1;
            end
        end
    end

    // Readback frame is loaded on a read strobe and held until the next one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_valid <= rd_stb;
            if (rd_stb) begin
                tx_data <= {2'b10, rp_reg, seg_tbl[rp_reg][rp_seg]};
            end
        end
    end

endmodule

// File: rtl/pll_cfg_assembler.sv
// PLL configuration assembler: decodes 16-bit SPI frames, assembles four
// 48-bit config words from 12-bit segments (MS first) and commits them
// atomically, owns run_en, the bad-frame counter and the readback path.
// Optional build macro CFG_TIMEOUT_EN adds an idle timeout that drops a
// stalled partial word after TIMEOUT_CYC cycles.
module pll_cfg_assembler
    import pll_cfg_pkg::*;
#(
    parameter int NUM_SEG = 4
`ifdef CFG_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4000
`endif
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               frame_valid,
    input  logic [15:0]                        frame_data,
    output logic [NUM_WORDS*SEG_W*NUM_SEG-1:0] cfg_word,
    output logic [NUM_WORDS-1:0]               cfg_update,
    output logic                               run_en,
    output logic                               tx_valid,
    output logic [15:0]                        tx_data,
    output logic [7:0]                         err_cnt
);

    localparam int WW  = SEG_W * NUM_SEG;
    localparam int SCW = $clog2(NUM_SEG);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [3:0]       cmd;
    logic [1:0]       wr_addr;
    logic [SEG_W-1:0] payload;
    logic             is_wr, is_rd, is_run, is_nop, is_bad;
    logic             start_seg, add_seg, commit;
    logic             timeout_hit;

    logic [1:0]                      state;
    logic [1:0]                      asm_addr;
    logic [SCW-1:0]                  seg_cnt;
    logic [WW-1:0]                   shadow;
    logic [NUM_WORDS-1:0][WW-1:0]    words;

    assign cmd     = frame_data[15:12];
    assign wr_addr = frame_data[13:12];
    assign payload = frame_data[11:0];

    assign is_wr  = frame_valid && (cmd[3:2] == CMD_WR);
    assign is_rd  = frame_valid && (cmd == CMD_RD);
    assign is_run = frame_valid && (cmd == CMD_RUN);
    assign is_nop = frame_valid && (cmd == CMD_NOP);
    assign is_bad = frame_valid && !(cmd[3:2] == CMD_WR) && !is_rd && !is_run && !is_nop;

    // A write outside ASM, or to a different address, starts a fresh word
    assign start_seg = is_wr && ((state != ST_ASM) || (wr_addr != asm_addr));
    assign add_seg   = is_wr && (state == ST_ASM) && (wr_addr == asm_addr);
    assign commit    = add_seg && (seg_cnt == SCW'(NUM_SEG-1));

    assign cfg_word = words;

`ifdef CFG_TIMEOUT_EN
    logic [15:0] idle_cnt;

    assign timeout_hit = (state == ST_ASM) && !frame_valid &&
                         (idle_cnt == 16'(TIMEOUT_CYC - 1));

    // Idle counter: runs only while a word is part-assembled, any frame clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if ((state == ST_ASM) && !frame_valid && !timeout_hit) begin
            idle_cnt <= idle_cnt + 16'd1;
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Assembly FSM, committed word storage and the per-word update pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            asm_addr   <= '0;
            seg_cnt    <= '0;
            words      <= '0;
            cfg_update <= '0;
        end else begin
            cfg_update <= '0;
            if (start_seg) begin
                state    <= ST_ASM;
                asm_addr <= wr_addr;
                seg_cnt  <= SCW'(1);
            end else if (commit) begin
                words[asm_addr]      <= {shadow[WW-SEG_W-1:0], payload};
                cfg_update[asm_addr] <= 1'b1;
                state                <= ST_COMMIT;
                seg_cnt              <= '0;
            end else if (add_seg) begin
                seg_cnt <= seg_cnt + 1'b1;
            end else if (timeout_hit) begin
                state   <= ST_IDLE;
                seg_cnt <= '0;
            end else if (state == ST_COMMIT) begin
                state <= ST_IDLE;
            end
        end
    end

    // Shadow shift register: segments arrive MS first, so shifting left lands them in place
    always_ff @(posedge clk) begin
        if (start_seg) begin
            shadow <= {{(WW-SEG_W){1'b0}}, payload};
        end else if (add_seg) begin
            shadow <= {shadow[WW-SEG_W-1:0], payload};
        end
    end

    // Run enable toggle and saturating bad-frame / timeout counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_en  <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (is_run) begin
                run_en <= !run_en;
            end
            if (is_bad || timeout_hit) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

    pll_cfg_readback #(
        .NUM_SEG (NUM_SEG)
    ) u_readback (
        .clk      (clk),
        .rst      (rst),
        .rd_stb   (is_rd),
        .ptr_clr  (is_nop),
        .cfg_word (cfg_word),
        .tx_valid (tx_valid),
        .tx_data  (tx_data)
    );

endmodule
